// File: rtl/module_spi_ctrl_pkg.sv
// Shared types and constants for the SPI master sequencer.
package pkg_spi;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD
  } spi_state_e;

  localparam int unsigned SPI_BITS = 8;

endpackage

// File: rtl/module_spi_ctrl_tick.sv
// Half-period counter: counts 0..DIV-1 while enabled, flags the final cycle of each half period.
module module_spi_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic enable,
  output logic last_o
);

  localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign last_o = (cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= last_o ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/module_spi_ctrl.sv
// SPI mode-0 master sequencer: generates sclk/cs and single-cycle strobes for the
// external MOSI/MISO shift registers, running bursts of 1..15 bytes.
module module_spi_ctrl #(
  parameter int unsigned DIV     = 4,
  parameter int unsigned NBYTE_W = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NBYTE_W-1:0] n_bytes_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               sclk_o,
  output logic               cs_o,
  output logic               clk_fn_o,
  output logic               shift_mosi_o,
  output logic               load_o,
  output logic               byte_done_o,
  output logic [NBYTE_W-1:0] byte_cnt_o
);

  import pkg_spi::*;

  localparam int unsigned BIT_W = 4;

  if (DIV < 2) begin : g_div_chk
    $error("module_spi_ctrl: DIV must be at least 2");
  end

  spi_state_e         state, state_n;
  logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
  logic [NBYTE_W-1:0] nbytes_q, nbytes_n;
  logic [NBYTE_W-1:0] byte_cnt_n;
  logic               busy_n, done_n, sclk_n, cs_n;
  logic               clk_fn_n, shift_n, load_n, bdone_n;
  logic               tick_last;

  module_spi_tick #(.DIV(DIV)) u_tick (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (state == IDLE),
    .enable (state != IDLE),
    .last_o (tick_last)
  );

  // State, counters and every output are registered together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      nbytes_q     <= '0;
      byte_cnt_o   <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      sclk_o       <= 1'b0;
      cs_o         <= 1'b1;
      clk_fn_o     <= 1'b0;
      shift_mosi_o <= 1'b0;
      load_o       <= 1'b0;
      byte_done_o  <= 1'b0;
    end else begin
      state        <= state_n;
      bit_cnt      <= bit_cnt_n;
      nbytes_q     <= nbytes_n;
      byte_cnt_o   <= byte_cnt_n;
      busy_o       <= busy_n;
      done_o       <= done_n;
      sclk_o       <= sclk_n;
      cs_o         <= cs_n;
      clk_fn_o     <= clk_fn_n;
      shift_mosi_o <= shift_n;
      load_o       <= load_n;
      byte_done_o  <= bdone_n;
    end
  end

  // Next-state and next-output values; strobes describe the cycle after the transition.
  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    nbytes_n   = nbytes_q;
    byte_cnt_n = byte_cnt_o;
    busy_n     = (state != IDLE);
    cs_n       = (state == IDLE);
    sclk_n     = (state == HIGH);
    done_n     = 1'b0;
    clk_fn_n   = 1'b0;
    shift_n    = 1'b0;
    load_n     = 1'b0;
    bdone_n    = 1'b0;

    case (state)
      IDLE: begin
        if (start_i && (n_bytes_i != '0)) begin
          state_n    = SETUP;
          busy_n     = 1'b1;
          cs_n       = 1'b0;
          load_n     = 1'b1;
          nbytes_n   = n_bytes_i;
          byte_cnt_n = '0;
          bit_cnt_n  = '0;
        end
      end
      SETUP: begin
        if (tick_last) begin
          state_n  = HIGH;
          sclk_n   = 1'b1;
          clk_fn_n = 1'b1;
        end
      end
      HIGH: begin
        if (tick_last) begin
          state_n = LOW;
          sclk_n  = 1'b0;
          if (bit_cnt == BIT_W'(SPI_BITS - 1)) begin
            bit_cnt_n  = BIT_W'(SPI_BITS);
            bdone_n    = 1'b1;
            byte_cnt_n = byte_cnt_o + NBYTE_W'(1);
            load_n     = ((byte_cnt_o + NBYTE_W'(1)) != nbytes_q);
          end else begin
            bit_cnt_n = bit_cnt + BIT_W'(1);
            shift_n   = 1'b1;
          end
        end
      end
      LOW: begin
        // Byte boundary: the count parks at 8 for the entry cycle only.
        if (bit_cnt == BIT_W'(SPI_BITS)) begin
          bit_cnt_n = '0;
        end
        if (tick_last) begin
          if (byte_cnt_o != nbytes_q) begin
            state_n  = HIGH;
            sclk_n   = 1'b1;
            clk_fn_n = 1'b1;
          end else begin
            state_n = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick_last) begin
          state_n = IDLE;
          cs_n    = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
